mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative HI/LO execution unit that consumes the 6-bit R-type function code produced by the ALU control decoder and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Sits beside the single-cycle ALU in the execute stage. It owns the architectural HI/LO registers, which MFHI/MFLO read directly. Raises `busy` so the control path stalls any MFHI/MFLO, MTHI/MTLO or new mult/div issued while an operation is in flight.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Iteration count equals `WIDTH`.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-low.
- `start`  in  1: issue strobe, sampled on rising `clk`.
- `fncode`  in  6: function code from the ALU control decoder.
- `op_a`  in  WIDTH: rs value. Multiplicand or dividend; source for MTHI/MTLO.
- `op_b`  in  WIDTH: rt value. Multiplier or divisor.
- `busy`  out  1: high while an iterative op is in flight.
- `done`  out  1: one-cycle pulse in the cycle HI/LO first show a mult/div result.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.

## Operation
- States: IDLE, MUL, DIV, FINISH.
- In IDLE with `start`=1, the unit decodes `fncode`:
  - MULT/MULTU: latch |op_a|, |op_b| and the result sign. Signed variant only; unsigned takes operands as-is. Go to MUL.
  - DIV/DIVU: latch |op_a|, |op_b|, quotient sign = sign(a)^sign(b), remainder sign = sign(a). Go to DIV.
  - MTHI: hi <= op_a. MTLO: lo <= op_a. Both complete on that edge, stay in IDLE, no `busy`, no `done`.
  - Any other code: ignored, stay in IDLE, HI/LO unchanged.
- `start` outside IDLE is ignored. No queueing; the control path must not issue while `busy`.
- MUL: radix-2 shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator. WIDTH iterations, then FINISH.
- DIV: restoring division, one quotient bit per cycle, WIDTH-bit partial remainder plus a carry bit. WIDTH iterations, then FINISH.
- FINISH:
  - Apply sign correction by two's-complement negation.
  - Mult writes {hi,lo} = 2·WIDTH product.
  - Div writes lo = quotient, hi = remainder.
  - Assert `done`, return to IDLE.
- Divide by zero (both variants): lo = all-ones, hi = op_a unchanged. Same latency, no exception.
- Signed overflow 0x80000000 / -1: lo = 0x80000000, hi = 0.
- HI/LO are written only in FINISH, or by MTHI/MTLO. Intermediate iterations never disturb the visible registers.

## Timing
- Reset values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, iteration counter 0.
- Reset asserted mid-operation aborts at that edge, giving the same values as reset. The partial result is discarded.
- Mult/div accepted at edge E0:
  - `busy`=1 from E0 through the edge that enters FINISH.
  - `busy` is also 1 in the FINISH cycle.
  - WIDTH iteration cycles follow E0, then 1 FINISH cycle.
  - `hi`/`lo` hold the new result after edge E0+WIDTH+1, with `done`=1 and `busy`=0 in that cycle.
  - Total: WIDTH+1 cycles from issue to result, i.e. 33 for WIDTH=32.
- A new `start` is accepted in the same cycle `done` is high (the unit is IDLE).
- MTHI/MTLO: result visible the cycle after the issue edge.
- Counter: log2(WIDTH)+1 bits, no wrap. Terminal count WIDTH-1 triggers the FINISH transition.

## Structure
- Shared package holds:
  - FUNCT_MULT/MULTU/DIV/DIVU/MTHI/MTLO, beside the existing FUNCT_* constants.
  - The `md_state_t` enum {IDLE, MUL, DIV, FINISH}.
- One natural sub-module: `seq_divider`, the restoring-division step plus counter. The multiplier path and HI/LO registers stay in the top.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles `done`=1, hi=0xFFFFFFFE, lo=0x00000001. `busy` high for exactly 33 cycles.
- MULT -3 × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x00001234. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0xAAAA5555 then MTLO 0x0F0F0F0F -> hi and lo updated on consecutive cycles, `busy` never asserted.
- Second `start` (MULTU 2×3) issued 5 cycles into a DIVU 100/7 -> ignored; result lo=14, hi=2.
- `reset` driven low 10 cycles into MULT -> next cycle IDLE, hi=lo=0, `busy`=`done`=0. A fresh MULTU 6×7 then yields lo=42, hi=0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the execute-stage HI/LO unit.
//   - R-type function codes produced by the ALU control decoder
//   - md_state_t: state encoding of the iterative mult/div sequencer
package mult_div_unit_pkg;

    // R-type function codes (instruction bits [5:0])
    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_SRL   = 6'h02;
    localparam logic [5:0] FUNCT_SRA   = 6'h03;
    localparam logic [5:0] FUNCT_JR    = 6'h08;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_SUBU  = 6'h23;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_NOR   = 6'h27;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } md_state_t;

endpackage

// File: rtl/mult_div_unit_seq_divider.sv
// seq_divider: restoring division, one quotient bit per step, plus the
// iteration counter shared by the multiplier and divider paths.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   load            capture dividend/divisor, clear remainder and counter
//   count_en        advance the iteration counter
//   div_en          perform one restoring-division step
//   dividend        unsigned dividend (magnitude)
//   divisor         unsigned divisor (magnitude)
//   quotient        quotient so far (final after WIDTH steps)
//   remainder       partial remainder (final after WIDTH steps)
//   last            counter sits at its terminal value WIDTH-1
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             count_en,
    input  logic             div_en,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] quo;   // dividend shifts out the top, quotient bits shift in
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   trial; // partial remainder plus carry bit
    logic [WIDTH+1:0] diff;  // one extra bit so the borrow is unambiguous

    always_comb begin
        trial = {rem, quo[WIDTH-1]};
        diff  = {1'b0, trial} - {2'b00, dvsr};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dvsr  <= '0;
            quo   <= '0;
            rem   <= '0;
            count <= '0;
        end else if (load) begin
            dvsr  <= divisor;
            quo   <= dividend;
            rem   <= '0;
            count <= '0;
        end else begin
            if (count_en)
                count <= count + 1'b1;
            if (div_en) begin
                // No borrow: trial >= divisor, keep the difference.
                // A zero divisor never borrows, giving all-ones quotient and
                // a remainder equal to the dividend.
                if (!diff[WIDTH+1]) begin
                    rem <= diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem;
    assign last      = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO unit for MULT, MULTU, DIV, DIVU, MTHI, MTLO.
// Owns the architectural HI/LO registers read by MFHI/MFLO.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   start        issue strobe, fncode/op_a/op_b sampled with it
//   fncode       R-type function code
//   op_a, op_b   rs / rt operands
//   busy         mult/div in flight (issue edge through the FINISH cycle)
//   done         one-cycle pulse when hi/lo first show a mult/div result
//   hi, lo       HI/LO registers
//   dbg_state    current sequencer state
//
// Issue handshake: start is accepted only in the cycle busy is low; an
// accepted MULT/DIV raises busy on the same edge and the control path must
// hold off further issues until busy drops. start while busy is dropped.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       fncode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output md_state_t        dbg_state
);

    md_state_t          state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;      // {partial product, remaining multiplier bits}
    logic               res_neg;  // product sign, or quotient sign for div
    logic               rem_neg;
    logic               is_div;

    logic               is_mul_op, is_div_op, signed_op;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic               load, last;
    logic [WIDTH-1:0]   quotient, remainder;

    always_comb begin
        is_mul_op = (fncode == FUNCT_MULT) || (fncode == FUNCT_MULTU);
        is_div_op = (fncode == FUNCT_DIV)  || (fncode == FUNCT_DIVU);
        signed_op = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
        abs_a     = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
        abs_b     = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
        load      = (state == IDLE) && start && (is_mul_op || is_div_op);
    end

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .count_en  ((state == MUL) || (state == DIV)),
        .div_en    (state == DIV),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (quotient),
        .remainder (remainder),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mcand   <= '0;
            acc     <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            is_div  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul_op) begin
                            mcand   <= abs_a;
                            acc     <= {{WIDTH{1'b0}}, abs_b};
                            res_neg <= signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                            is_div  <= 1'b0;
                            busy    <= 1'b1;
                            state   <= MUL;
                        end else if (is_div_op) begin
                            // Divide by zero keeps an unsigned all-ones quotient,
                            // so the quotient sign flip is suppressed for it.
                            res_neg <= signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1])
                                       && (op_b != '0);
                            rem_neg <= signed_op && op_a[WIDTH-1];
                            is_div  <= 1'b1;
                            busy    <= 1'b1;
                            state   <= DIV;
                        end else if (fncode == FUNCT_MTHI) begin
                            hi <= op_a;
                        end else if (fncode == FUNCT_MTLO) begin
                            lo <= op_a;
                        end
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    if (last)
                        state <= FINISH;
                end
                DIV: begin
                    if (last)
                        state <= FINISH;
                end
                FINISH: begin
                    if (is_div) begin
                        lo <= res_neg ? -quotient  : quotient;
                        hi <= rem_neg ? -remainder : remainder;
                    end else begin
                        {hi, lo} <= res_neg ? -acc : acc;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: driver tasks issue operations and
// push expected {hi,lo} into exp_q; a monitor pops and compares on done.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [5:0]       fncode = '0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;
    md_state_t        dbg_state;

    int               total_cnt = 0;
    int               pass_cnt  = 0;
    logic [63:0]      exp_q[$];

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .fncode    (fncode),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h, expected no result", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    check("result_hi", 64'(hi), 64'(e[63:32]));
                    check("result_lo", 64'(lo), 64'(e[31:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at the negedge right after the issue edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        fncode = f;
        op_a   = a;
        op_b   = b;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts busy cycles until done, bounded.
    task automatic wait_done(output int cycles);
        int guard;
        cycles = 0;
        guard  = 0;
        while (done !== 1'b1 && guard < 200) begin
            if (busy === 1'b1) cycles++;
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int cycles;
        exp_q.push_back(exp);
        issue(f, a, b);
        wait_done(cycles);
        check({name, "_done_seen"}, 64'(done), 64'(1));
        check({name, "_busy_cycles"}, 64'(cycles), 64'(33));
        check({name, "_busy_low_at_done"}, 64'(busy), 64'(0));
        @(negedge clk);
        check({name, "_done_pulse_1cyc"}, 64'(done), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cycles;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hi", 64'(hi), 64'(0));
        check("reset_lo", 64'(lo), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(IDLE));
        reset = 1'b1;

        run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mult_minmin", FUNCT_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("div_neg", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", FUNCT_DIVU, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
        run_op("div_zero_neg", FUNCT_DIV, 32'hFFFF_FFF0, 32'd0, 64'hFFFF_FFF0_FFFF_FFFF);
        run_op("div_overflow", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        start = 1'b1; fncode = FUNCT_MTHI; op_a = 32'hAAAA_5555; op_b = '0;
        @(negedge clk);
        check("mthi_hi", 64'(hi), 64'hAAAA_5555);
        check("mthi_busy", 64'(busy), 64'(0));
        fncode = FUNCT_MTLO; op_a = 32'h0F0F_0F0F;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h0F0F_0F0F);
        check("mtlo_hi_kept", 64'(hi), 64'hAAAA_5555);
        check("mtlo_busy", 64'(busy), 64'(0));
        check("mtlo_done", 64'(done), 64'(0));

        // Non-mult/div code leaves HI/LO alone
        issue(FUNCT_ADD, 32'h1111_1111, 32'h2222_2222);
        check("ignored_hi", 64'(hi), 64'hAAAA_5555);
        check("ignored_lo", 64'(lo), 64'h0F0F_0F0F);
        check("ignored_busy", 64'(busy), 64'(0));

        // Second start 5 cycles into DIVU 100/7 is dropped
        exp_q.push_back({32'd2, 32'd14});
        issue(FUNCT_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; fncode = FUNCT_MULTU; op_a = 32'd2; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("dropped_start_busy", 64'(busy), 64'(1));
        check("dropped_start_state", 64'(dbg_state), 64'(DIV));
        wait_done(cycles);
        check("divu_7_done_seen", 64'(done), 64'(1));
        @(negedge clk);
        check("no_second_result_state", 64'(dbg_state), 64'(IDLE));

        // Reset 10 cycles into MULT aborts it
        issue(FUNCT_MULT, 32'd5, 32'd9);
        repeat (9) @(negedge clk);
        check("pre_abort_busy", 64'(busy), 64'(1));
        reset = 1'b0;
        @(negedge clk);
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        reset = 1'b1;

        run_op("multu_after_reset", FUNCT_MULTU, 32'd6, 32'd7, 64'h0000_0000_0000_002A);

        repeat (40) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
